ext_stream: RTL and testbench
=============================

# ext_stream

Parametrised, pipelined immediate and load-data extender for the pipelined MIPS datapath. It accepts an operand word, a byte offset, a mode and a tag through a valid/ready handshake. It computes sign, zero or upper-placement extension of a 16-bit immediate, or byte/halfword/word extraction with extension of load data. The result is buffered in a 2-entry skid FIFO, so the block sits between the DM read stage and write-back (or ID and EX) without stalling at full throughput.

## Interface
- DATA_W, 32: operand/result width; multiple of 16, at least 32.
- TAG_W, 5: sideband tag width (destination register number); passed through unchanged.
- OFF_W, $clog2(DATA_W/8): byte-offset width (derived, not overridden).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- flush  in  1  synchronous; discards buffered entries.
- in_valid  in  1  input entry present.
- in_ready  out  1  block can accept an entry this cycle.
- in_data  in  DATA_W  immediate (low 16 bits used) or loaded word.
- in_off  in  OFF_W  byte offset for subword modes.
- in_mode  in  3  extension mode (see Operation).
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head entry this cycle.
- out_data  out  DATA_W  extended result of head entry.
- out_tag  out  TAG_W  tag of head entry.
- out_err  out  1  head entry was misaligned; out_data is 0 for such entries.

## Operation
- Modes:
  - 0 SIGN16: {sign(in_data[15]), in_data[15:0]}.
  - 1 ZERO16: zero-extended in_data[15:0].
  - 2 LUI: in_data[15:0] in bits [DATA_W-1:DATA_W-16], zeros below.
  - 3 LB: byte at in_off, sign-extended.
  - 4 LBU: byte at in_off, zero-extended.
  - 5 LH: halfword at in_off[OFF_W-1:1], sign-extended.
  - 6 LHU: halfword at in_off[OFF_W-1:1], zero-extended.
  - 7 WORD: in_data[31:0], sign-extended to DATA_W when DATA_W>32.
- Byte lanes are little-endian: byte k = in_data[8k+7:8k].
- in_off is ignored in modes 0, 1, 2 and 7.
- Misalignment: modes 5/6 with in_off[0]=1 store err=1 and data=0. The entry still flows through the FIFO in order.
- Result is computed combinationally at push. The FIFO stores {data, tag, err}, never raw inputs.
- FIFO: 2 entries, in-order, count 0..2.
  - Push = in_valid & in_ready.
  - Pop = out_valid & out_ready.
  - in_ready = (count != 2), driven from the registered count with no combinational path from out_ready.
  - out_valid = (count != 0).
  - Head outputs come from registered storage.
- Simultaneous push and pop at count 1: count stays 1; the new entry becomes head next cycle.
- Push and pop at count 0: pop is impossible (out_valid=0), so it is not applicable.
- flush=1: count becomes 0 next edge. Flush has priority over a same-cycle push, and the pushed entry is dropped. in_ready stays per current count.
- Read/write pointers are 1 bit and wrap 1→0.

## Timing
- Reset values: out_valid=0, in_ready=1, out_data=0, out_tag=0, out_err=0, count=0, pointers=0.
- Reset asserted mid-transfer drops all entries asynchronously. No entry is emitted after reset deasserts until a new push.
- Latency: entry pushed in cycle N appears at out_* in cycle N+1 when the FIFO was empty.
- Throughput: 1 entry/cycle while out_ready=1.
- out_ready low for one cycle with continuous input: count reaches 2, in_ready drops the following cycle, and no entry is lost.
- out_data/out_tag/out_err hold stable while out_valid=1 and out_ready=0.

## Structure
- Shared package ext_pkg holds:
  - the 3-bit mode encodings EXT_SIGN16..EXT_WORD;
  - a FIFO entry struct {data, tag, err}, parametrised by DATA_W/TAG_W via the instantiating module.
- Sub-module ext_core: purely combinational mode/offset → {data, err}. It is instantiated once at the push side. The FIFO and control stay in ext_stream.

## Test plan
- Immediate modes, DATA_W=32, out_ready=1:
  - SIGN16 in_data=0x0000_8001 → 0xFFFF_8001.
  - ZERO16 same → 0x0000_8001.
  - LUI 0x0000_1234 → 0x1234_0000.
  - Each appears exactly 1 cycle after push.
- Load modes, in_data=0x80FF_7F01:
  - LB off=3 → 0xFFFF_FF80; LBU off=1 → 0x0000_007F.
  - LH off=2 → 0xFFFF_80FF; LHU off=0 → 0x0000_7F01.
  - LH off=1 → err=1, data=0; tag preserved.
- Backpressure: stream tags 1..6 with out_ready low at cycles 2–3.
  - in_ready deasserts when count=2.
  - Outputs stay stable while stalled.
  - All tags emerge in order 1..6 with no drop or duplicate.
- Flush with count=2 and a simultaneous push: next cycle out_valid=0, in_ready=1, and the pushed entry never appears.
- Asynchronous reset asserted between clock edges with count=1: out_valid drops to 0 before the next edge, all outputs read 0, and in_ready=1.
- Parameter sweep DATA_W=64: LUI 0xABCD → 0xABCD_0000_0000_0000; WORD 0x8000_0000 → 0xFFFF_FFFF_8000_0000; LB off=7 selects bits [63:56].

Source files
------------

// File: rtl/ext_pkg.sv
// Shared definitions for the immediate/load-data extender: mode encodings.
package ext_pkg;

   typedef enum logic [2:0] {
      EXT_SIGN16 = 3'd0,
      EXT_ZERO16 = 3'd1,
      EXT_LUI    = 3'd2,
      EXT_LB     = 3'd3,
      EXT_LBU    = 3'd4,
      EXT_LH     = 3'd5,
      EXT_LHU    = 3'd6,
      EXT_WORD   = 3'd7
   } ext_mode_e;

   localparam int EXT_FIFO_DEPTH = 2;

endpackage

// File: rtl/ext_core.sv
// Combinational extender: selects an immediate placement or a little-endian
// byte/halfword lane of the operand and extends it to DATA_W.
module ext_core
   import ext_pkg::*;
#(
   parameter  int DATA_W = 32,
   localparam int OFF_W  = $clog2(DATA_W/8),
   localparam int NB     = DATA_W/8
) (
   input  logic [DATA_W-1:0] data,
   input  logic [OFF_W-1:0]  off,
   input  logic [2:0]        mode,
   output logic [DATA_W-1:0] result,
   output logic              err
);

   logic [7:0]        byte_lane [NB];
   logic [15:0]       half_lane [NB/2];
   logic [7:0]        sel_b;
   logic [15:0]       sel_h;
   logic [DATA_W-1:0] word_ext;

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_byte
         assign byte_lane[gi] = data[8*gi +: 8];
      end
      for (gi = 0; gi < NB/2; gi++) begin : g_half
         assign half_lane[gi] = data[16*gi +: 16];
      end
      if (DATA_W > 32) begin : g_wide
         assign word_ext = {{(DATA_W-32){data[31]}}, data[31:0]};
      end else begin : g_narrow
         assign word_ext = data[31:0];
      end
   endgenerate

   assign sel_b = byte_lane[off];
   assign sel_h = half_lane[off[OFF_W-1:1]];

   always_comb begin
      result = '0;
      err    = 1'b0;
      case (mode)
         EXT_SIGN16: result = {{(DATA_W-16){data[15]}}, data[15:0]};
         EXT_ZERO16: result = {{(DATA_W-16){1'b0}}, data[15:0]};
         EXT_LUI:    result = {data[15:0], {(DATA_W-16){1'b0}}};
         EXT_LB:     result = {{(DATA_W-8){sel_b[7]}}, sel_b};
         EXT_LBU:    result = {{(DATA_W-8){1'b0}}, sel_b};
         // Odd halfword offsets are flagged and produce a zero result.
         EXT_LH: begin
            if (off[0]) err = 1'b1;
            else        result = {{(DATA_W-16){sel_h[15]}}, sel_h};
         end
         EXT_LHU: begin
            if (off[0]) err = 1'b1;
            else        result = {{(DATA_W-16){1'b0}}, sel_h};
         end
         EXT_WORD:   result = word_ext;
         default:    result = '0;
      endcase
   end

endmodule

// File: rtl/ext_stream.sv
// Extender with valid/ready input and a 2-entry in-order skid FIFO holding
// finished results; in_ready depends only on the registered count.
module ext_stream
   import ext_pkg::*;
#(
   parameter  int DATA_W = 32,
   parameter  int TAG_W  = 5,
   localparam int OFF_W  = $clog2(DATA_W/8)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [OFF_W-1:0]  in_off,
   input  logic [2:0]        in_mode,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_err
);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [TAG_W-1:0]  tag;
      logic              err;
   } entry_t;

   entry_t            mem_reg [EXT_FIFO_DEPTH];
   entry_t            push_entry;
   logic              wr_ptr_reg;
   logic              rd_ptr_reg;
   logic [1:0]        count_reg;
   logic [1:0]        count_next;
   logic [DATA_W-1:0] core_data;
   logic              core_err;
   logic              push;
   logic              pop;

   ext_core #(.DATA_W(DATA_W)) u_core (
      .data   (in_data),
      .off    (in_off),
      .mode   (in_mode),
      .result (core_data),
      .err    (core_err)
   );

   assign push_entry = '{data: core_data, tag: in_tag, err: core_err};
   assign in_ready   = (count_reg != 2'd2);
   assign out_valid  = (count_reg != 2'd0);
   assign push       = in_valid & in_ready;
   assign pop        = out_valid & out_ready;

   always_comb begin
      count_next = count_reg;
      if (push && !pop)      count_next = count_reg + 2'd1;
      else if (pop && !push) count_next = count_reg - 2'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_reg  <= 2'd0;
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         mem_reg[0] <= '0;
         mem_reg[1] <= '0;
      end else if (flush) begin
         // A push in the same cycle as flush is deliberately dropped.
         count_reg  <= 2'd0;
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
      end else begin
         if (push) begin
            mem_reg[wr_ptr_reg] <= push_entry;
            wr_ptr_reg          <= ~wr_ptr_reg;
         end
         if (pop) rd_ptr_reg <= ~rd_ptr_reg;
         count_reg <= count_next;
      end
   end

   assign out_data = mem_reg[rd_ptr_reg].data;
   assign out_tag  = mem_reg[rd_ptr_reg].tag;
   assign out_err  = mem_reg[rd_ptr_reg].err;

endmodule

// File: tb/tb_ext_stream.sv
// Bench for ext_stream: vector tables, directed corner sequences and a random
// stream checked against a queue-based reference model.
module tb_ext_stream;
   import ext_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic [1:0]  in_off = '0;
   logic [2:0]  in_mode = '0;
   logic [4:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_data;
   logic [4:0]  out_tag;
   logic        out_err;

   logic        w_flush = 1'b0;
   logic        w_in_valid = 1'b0;
   logic        w_in_ready;
   logic [63:0] w_in_data = '0;
   logic [2:0]  w_in_off = '0;
   logic [2:0]  w_in_mode = '0;
   logic [4:0]  w_in_tag = '0;
   logic        w_out_valid;
   logic        w_out_ready = 1'b1;
   logic [63:0] w_out_data;
   logic [4:0]  w_out_tag;
   logic        w_out_err;

   always #5 clk = ~clk;

   ext_stream #(.DATA_W(32), .TAG_W(5)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_off(in_off), .in_mode(in_mode), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_tag(out_tag), .out_err(out_err)
   );

   ext_stream #(.DATA_W(64), .TAG_W(5)) dut64 (
      .clk(clk), .reset(reset), .flush(w_flush),
      .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
      .in_off(w_in_off), .in_mode(w_in_mode), .in_tag(w_in_tag),
      .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
      .out_tag(w_out_tag), .out_err(w_out_err)
   );

   typedef struct {
      logic [63:0] data;
      int          tag;
      bit          err;
   } exp_t;

   typedef struct {
      int          mode;
      logic [63:0] data;
      int          off;
      int          tag;
      logic [63:0] exp_data;
      bit          exp_err;
   } vec_t;

   int   checks = 0;
   int   failures = 0;
   exp_t q[$];
   int   emitted[$];
   bit   last_push;
   vec_t vt32[11];
   vec_t vt64[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] sext(input logic [63:0] v, input int bits);
      logic [63:0] hi;
      hi = ~64'd0 << bits;
      return v[bits-1] ? (v | hi) : v;
   endfunction

   // Reference extension computed from the mode rules with shifts and masks.
   function automatic void ref_ext(input int w, input logic [63:0] d, input int off,
                                   input int mode, output logic [63:0] r, output bit e);
      logic [63:0] mask;
      logic [63:0] b;
      logic [63:0] h;
      mask = (w == 64) ? ~64'd0 : ((64'd1 << w) - 64'd1);
      b = (d >> (8 * off)) & 64'hFF;
      h = (d >> (16 * (off / 2))) & 64'hFFFF;
      e = 1'b0;
      case (mode)
         0: r = sext(d & 64'hFFFF, 16) & mask;
         1: r = d & 64'hFFFF;
         2: r = ((d & 64'hFFFF) << (w - 16)) & mask;
         3: r = sext(b, 8) & mask;
         4: r = b;
         5, 6: begin
            if (off % 2 == 1) begin
               e = 1'b1;
               r = 64'd0;
            end else begin
               r = (mode == 5) ? (sext(h, 16) & mask) : h;
            end
         end
         default: r = sext(d & 64'hFFFF_FFFF, 32) & mask;
      endcase
   endfunction

   task automatic compare_model();
      check("out_valid", 64'(out_valid), 64'(q.size() != 0));
      check("in_ready", 64'(in_ready), 64'(q.size() != 2));
      if (q.size() != 0) begin
         check("head_data", 64'(out_data), q[0].data);
         check("head_tag", 64'(out_tag), 64'(q[0].tag));
         check("head_err", 64'(out_err), 64'(q[0].err));
      end
   endtask

   task automatic drive(input bit v, input logic [31:0] d, input int off, input int mode,
                        input int tag, input bit rdy, input bit fl);
      bit   do_push;
      bit   do_pop;
      exp_t e;
      in_valid  = v;
      in_data   = d;
      in_off    = 2'(off);
      in_mode   = 3'(mode);
      in_tag    = 5'(tag);
      out_ready = rdy;
      flush     = fl;
      do_push   = v && (q.size() != 2);
      do_pop    = rdy && (q.size() != 0);
      last_push = do_push && !fl;
      if (fl) begin
         q.delete();
      end else begin
         if (do_pop) begin
            emitted.push_back(q[0].tag);
            void'(q.pop_front());
         end
         if (do_push) begin
            ref_ext(32, {32'd0, d}, off, mode, e.data, e.err);
            e.tag = tag;
            q.push_back(e);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         compare_model();
         drive(1'b0, 32'd0, 0, 0, 0, 1'b1, 1'b0);
      end
   endtask

   initial begin
      vt32[0]  = '{EXT_SIGN16, 64'h0000_8001, 0, 1,  64'hFFFF_8001, 1'b0};
      vt32[1]  = '{EXT_ZERO16, 64'h0000_8001, 0, 2,  64'h0000_8001, 1'b0};
      vt32[2]  = '{EXT_LUI,    64'h0000_1234, 0, 3,  64'h1234_0000, 1'b0};
      vt32[3]  = '{EXT_LB,     64'h80FF_7F01, 3, 4,  64'hFFFF_FF80, 1'b0};
      vt32[4]  = '{EXT_LBU,    64'h80FF_7F01, 1, 5,  64'h0000_007F, 1'b0};
      vt32[5]  = '{EXT_LH,     64'h80FF_7F01, 2, 6,  64'hFFFF_80FF, 1'b0};
      vt32[6]  = '{EXT_LHU,    64'h80FF_7F01, 0, 7,  64'h0000_7F01, 1'b0};
      vt32[7]  = '{EXT_LH,     64'h80FF_7F01, 1, 8,  64'h0000_0000, 1'b1};
      vt32[8]  = '{EXT_WORD,   64'h80FF_7F01, 2, 9,  64'h80FF_7F01, 1'b0};
      vt32[9]  = '{EXT_LBU,    64'h80FF_7F01, 2, 10, 64'h0000_00FF, 1'b0};
      vt32[10] = '{EXT_SIGN16, 64'h1234_7FFF, 3, 11, 64'h0000_7FFF, 1'b0};

      vt64[0] = '{EXT_LUI,    64'h0000_0000_0000_ABCD, 0, 1, 64'hABCD_0000_0000_0000, 1'b0};
      vt64[1] = '{EXT_WORD,   64'h0000_0000_8000_0000, 0, 2, 64'hFFFF_FFFF_8000_0000, 1'b0};
      vt64[2] = '{EXT_LB,     64'h8100_0000_0000_0000, 7, 3, 64'hFFFF_FFFF_FFFF_FF81, 1'b0};
      vt64[3] = '{EXT_LBU,    64'h8100_0000_0000_0000, 7, 4, 64'h0000_0000_0000_0081, 1'b0};
      vt64[4] = '{EXT_LHU,    64'hBEEF_0000_0000_0000, 6, 5, 64'h0000_0000_0000_BEEF, 1'b0};
      vt64[5] = '{EXT_SIGN16, 64'h0000_0000_0000_8001, 5, 6, 64'hFFFF_FFFF_FFFF_8001, 1'b0};
      vt64[6] = '{EXT_LH,     64'h0000_9876_0000_0000, 5, 7, 64'h0000_0000_0000_0000, 1'b1};
      vt64[7] = '{EXT_LH,     64'h0000_9876_0000_0000, 4, 8, 64'hFFFF_FFFF_FFFF_9876, 1'b0};

      // Reset state.
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_tag", 64'(out_tag), 64'd0);
      check("rst_out_err", 64'(out_err), 64'd0);
      check("rst_w_out_valid", 64'(w_out_valid), 64'd0);
      reset = 1'b0;

      // Vector table: one push, result must be at the head one cycle later.
      foreach (vt32[i]) begin
         @(negedge clk);
         compare_model();
         drive(1'b1, vt32[i].data[31:0], vt32[i].off, vt32[i].mode, vt32[i].tag, 1'b1, 1'b0);
         @(negedge clk);
         check("vec_valid", 64'(out_valid), 64'd1);
         check("vec_data", 64'(out_data), vt32[i].exp_data);
         check("vec_err", 64'(out_err), 64'(vt32[i].exp_err));
         check("vec_tag", 64'(out_tag), 64'(vt32[i].tag));
         compare_model();
         drive(1'b0, 32'd0, 0, 0, 0, 1'b1, 1'b0);
      end
      idle(2);

      // Backpressure: tags 1..6, consumer stalls in loop cycles 2 and 3.
      begin
         int nt;
         nt = 1;
         emitted.delete();
         for (int cyc = 0; cyc < 40 && emitted.size() < 6; cyc++) begin
            @(negedge clk);
            compare_model();
            drive(nt <= 6, 32'h0000_1000 + 32'(nt), 0, EXT_WORD, nt,
                  !(cyc == 2 || cyc == 3), 1'b0);
            if (last_push) nt++;
         end
         check("bp_count", 64'(emitted.size()), 64'd6);
         for (int i = 0; i < emitted.size() && i < 6; i++)
            check("bp_order", 64'(emitted[i]), 64'(i + 1));
         idle(2);
      end

      // Flush at count=2 with a push attempt, then at count=1 with a push.
      @(negedge clk); compare_model(); drive(1'b1, 32'hAAAA_0001, 0, EXT_WORD, 20, 1'b0, 1'b0);
      @(negedge clk); compare_model(); drive(1'b1, 32'hAAAA_0002, 0, EXT_WORD, 21, 1'b0, 1'b0);
      @(negedge clk); compare_model(); drive(1'b1, 32'hAAAA_0003, 0, EXT_WORD, 31, 1'b0, 1'b1);
      @(negedge clk);
      check("flush2_out_valid", 64'(out_valid), 64'd0);
      check("flush2_in_ready", 64'(in_ready), 64'd1);
      compare_model(); drive(1'b1, 32'hBBBB_0001, 0, EXT_WORD, 22, 1'b0, 1'b0);
      @(negedge clk); compare_model(); drive(1'b1, 32'hBBBB_0002, 0, EXT_WORD, 30, 1'b1, 1'b1);
      @(negedge clk);
      check("flush1_out_valid", 64'(out_valid), 64'd0);
      compare_model(); drive(1'b0, 32'd0, 0, 0, 0, 1'b1, 1'b0);
      idle(3);

      // Asynchronous reset between edges with one entry held.
      @(negedge clk); compare_model(); drive(1'b1, 32'hC0DE_F00D, 0, EXT_WORD, 13, 1'b0, 1'b0);
      @(negedge clk); compare_model(); drive(1'b0, 32'd0, 0, 0, 0, 1'b0, 1'b0);
      #2 reset = 1'b1;
      #1;
      check("arst_out_valid", 64'(out_valid), 64'd0);
      check("arst_in_ready", 64'(in_ready), 64'd1);
      check("arst_out_data", 64'(out_data), 64'd0);
      check("arst_out_tag", 64'(out_tag), 64'd0);
      check("arst_out_err", 64'(out_err), 64'd0);
      #1 reset = 1'b0;
      q.delete();
      idle(3);

      // Random stream against the reference model.
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         compare_model();
         drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3),
               $urandom_range(0, 7), $urandom_range(0, 31),
               $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
      end
      idle(3);

      // DATA_W=64 instance.
      foreach (vt64[i]) begin
         @(negedge clk);
         w_in_valid = 1'b1;
         w_in_data  = vt64[i].data;
         w_in_off   = 3'(vt64[i].off);
         w_in_mode  = 3'(vt64[i].mode);
         w_in_tag   = 5'(vt64[i].tag);
         @(negedge clk);
         w_in_valid = 1'b0;
         check("w_valid", 64'(w_out_valid), 64'd1);
         check("w_data", w_out_data, vt64[i].exp_data);
         check("w_err", 64'(w_out_err), 64'(vt64[i].exp_err));
         check("w_tag", 64'(w_out_tag), 64'(vt64[i].tag));
         begin
            logic [63:0] r;
            bit          e;
            ref_ext(64, vt64[i].data, vt64[i].off, vt64[i].mode, r, e);
            check("w_model_data", w_out_data, r);
         end
      end
      @(negedge clk);
      check("w_drained", 64'(w_out_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
